// File: rtl/fir_ctrl_if.sv
// AXI-lite register channel bundle between a bus master and the FIR controller.
// Purely structural: no timing or storage of its own.
// The master drives valids, addresses, wdata and rready; the slave drives the readies, rvalid and rdata.
interface fir_ctrl_if #(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32
);
    logic                   awvalid;
    logic                   awready;
    logic [pADDR_WIDTH-1:0] awaddr;
    logic                   wvalid;
    logic                   wready;
    logic [pDATA_WIDTH-1:0] wdata;
    logic                   arvalid;
    logic                   arready;
    logic [pADDR_WIDTH-1:0] araddr;
    logic                   rvalid;
    logic                   rready;
    logic [pDATA_WIDTH-1:0] rdata;

    modport master (
        output awvalid, awaddr, wvalid, wdata, arvalid, araddr, rready,
        input  awready, wready, arready, rvalid, rdata
    );

    modport slave (
        input  awvalid, awaddr, wvalid, wdata, arvalid, araddr, rready,
        output awready, wready, arready, rvalid, rdata
    );
endinterface

// File: rtl/fir_ctrl.sv
// FIR control front end: AXI-lite registers and tap BRAM access, engine start/done handshake.
// Writes commit one cycle after address and data are both latched; register reads give rvalid 1 cycle after accept, tap reads 2.
// aw/w stall while their latch is full; ar stalls outside R_IDLE and during a tap write commit; rdata holds until rready.
module fir_ctrl #(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32,
    parameter int Tape_Num    = 11
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst_n,
    fir_ctrl_if.slave              axil,
    output logic [3:0]             tap_WE,
    output logic                   tap_EN,
    output logic [pDATA_WIDTH-1:0] tap_Di,
    output logic [pADDR_WIDTH-1:0] tap_A,
    input  logic [pDATA_WIDTH-1:0] tap_Do,
    input  logic                   eng_tap_EN,
    input  logic [pADDR_WIDTH-1:0] eng_tap_A,
    output logic                   eng_start,
    input  logic                   eng_done,
    output logic [pDATA_WIDTH-1:0] data_length
);

    localparam logic [pADDR_WIDTH-1:0] ADDR_CTRL = '0;
    localparam logic [pADDR_WIDTH-1:0] ADDR_LEN  = pADDR_WIDTH'(16);
    localparam logic [pADDR_WIDTH-1:0] TAP_BASE  = pADDR_WIDTH'(32);
    localparam logic [pADDR_WIDTH-1:0] TAP_END   = pADDR_WIDTH'(32 + 4 * Tape_Num);

    typedef enum logic [1:0] {
        R_IDLE,
        R_BRAM,
        R_RESP
    } rd_state_e;

    function automatic logic is_tap(input logic [pADDR_WIDTH-1:0] a);
        return (a >= TAP_BASE) && (a < TAP_END) && (a[1:0] == 2'b00);
    endfunction

    logic                   aw_full_q, aw_full_d;
    logic [pADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic                   w_full_q, w_full_d;
    logic [pDATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                   ap_idle_q, ap_idle_d;
    logic                   ap_done_q, ap_done_d;
    logic                   ap_start_q, ap_start_d;
    logic                   eng_start_q, eng_start_d;
    logic [pDATA_WIDTH-1:0] data_length_q, data_length_d;
    rd_state_e              rstate_q, rstate_d;
    logic [pDATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                   rd_ctrl_q, rd_ctrl_d;

    logic                   commit;
    logic                   wr_tap;
    logic                   ar_rdy;
    logic                   ar_hs;
    logic                   rd_tap;
    logic                   r_hs;
    logic [pDATA_WIDTH-1:0] ctrl_word;

    assign commit    = aw_full_q & w_full_q;
    // A tap write commit owns the BRAM port this cycle, so a new read must wait.
    assign wr_tap    = commit & ap_idle_q & is_tap(awaddr_q);
    assign ar_rdy    = (rstate_q == R_IDLE) & ~wr_tap;
    assign ar_hs     = axil.arvalid & ar_rdy;
    assign rd_tap    = ar_hs & ap_idle_q & is_tap(axil.araddr);
    assign r_hs      = (rstate_q == R_RESP) & axil.rready;
    assign ctrl_word = {{(pDATA_WIDTH-3){1'b0}}, ap_idle_q, ap_done_q, ap_start_q};

    // Address and data latches fill independently and drain together on commit.
    always_comb begin
        aw_full_d = aw_full_q;
        awaddr_d  = awaddr_q;
        w_full_d  = w_full_q;
        wdata_d   = wdata_q;
        if (commit) begin
            aw_full_d = 1'b0;
            w_full_d  = 1'b0;
        end else begin
            if (axil.awvalid && !aw_full_q) begin
                aw_full_d = 1'b1;
                awaddr_d  = axil.awaddr;
            end
            if (axil.wvalid && !w_full_q) begin
                w_full_d = 1'b1;
                wdata_d  = axil.wdata;
            end
        end
    end

    always_comb begin
        ap_idle_d     = ap_idle_q;
        ap_done_d     = ap_done_q;
        ap_start_d    = 1'b0;
        eng_start_d   = 1'b0;
        data_length_d = data_length_q;
        if (commit && ap_idle_q) begin
            if (awaddr_q == ADDR_CTRL && wdata_q[0]) begin
                eng_start_d = 1'b1;
                ap_start_d  = 1'b1;
                ap_idle_d   = 1'b0;
                ap_done_d   = 1'b0;
            end else if (awaddr_q == ADDR_LEN) begin
                data_length_d = wdata_q;
            end
        end
        if (r_hs && rd_ctrl_q) begin
            ap_done_d = 1'b0;
        end
        // Completion is applied last so it beats a same-cycle read-clear.
        if (eng_done && !ap_idle_q) begin
            ap_done_d = 1'b1;
            ap_idle_d = 1'b1;
        end
    end

    always_comb begin
        rstate_d  = rstate_q;
        rdata_d   = rdata_q;
        rd_ctrl_d = rd_ctrl_q;
        case (rstate_q)
            R_IDLE: begin
                if (ar_hs) begin
                    rd_ctrl_d = (axil.araddr == ADDR_CTRL);
                    if (rd_tap) begin
                        rstate_d = R_BRAM;
                    end else begin
                        rstate_d = R_RESP;
                        if (axil.araddr == ADDR_CTRL)
                            rdata_d = ctrl_word;
                        else if (axil.araddr == ADDR_LEN)
                            rdata_d = data_length_q;
                        else if (is_tap(axil.araddr))
                            rdata_d = '1;
                        else
                            rdata_d = '0;
                    end
                end
            end
            R_BRAM: begin
                rstate_d = R_RESP;
                rdata_d  = tap_Do;
            end
            R_RESP: begin
                if (axil.rready)
                    rstate_d = R_IDLE;
            end
            default: rstate_d = R_IDLE;
        endcase
    end

    // Tap BRAM port: the engine owns it while busy, AXI-lite otherwise.
    always_comb begin
        tap_EN = 1'b0;
        tap_WE = 4'b0000;
        tap_A  = '0;
        tap_Di = '0;
        if (!ap_idle_q) begin
            tap_EN = eng_tap_EN;
            tap_A  = eng_tap_A;
        end else if (wr_tap) begin
            tap_EN = 1'b1;
            tap_WE = 4'b1111;
            tap_A  = awaddr_q - TAP_BASE;
            tap_Di = wdata_q;
        end else if (rd_tap) begin
            tap_EN = 1'b1;
            tap_A  = axil.araddr - TAP_BASE;
        end
    end

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            aw_full_q     <= 1'b0;
            awaddr_q      <= '0;
            w_full_q      <= 1'b0;
            wdata_q       <= '0;
            ap_idle_q     <= 1'b1;
            ap_done_q     <= 1'b0;
            ap_start_q    <= 1'b0;
            eng_start_q   <= 1'b0;
            data_length_q <= '0;
            rstate_q      <= R_IDLE;
            rdata_q       <= '0;
            rd_ctrl_q     <= 1'b0;
        end else begin
            aw_full_q     <= aw_full_d;
            awaddr_q      <= awaddr_d;
            w_full_q      <= w_full_d;
            wdata_q       <= wdata_d;
            ap_idle_q     <= ap_idle_d;
            ap_done_q     <= ap_done_d;
            ap_start_q    <= ap_start_d;
            eng_start_q   <= eng_start_d;
            data_length_q <= data_length_d;
            rstate_q      <= rstate_d;
            rdata_q       <= rdata_d;
            rd_ctrl_q     <= rd_ctrl_d;
        end
    end

    assign axil.awready = ~aw_full_q;
    assign axil.wready  = ~w_full_q;
    assign axil.arready = ar_rdy;
    assign axil.rvalid  = (rstate_q == R_RESP);
    assign axil.rdata   = rdata_q;
    assign eng_start    = eng_start_q;
    assign data_length  = data_length_q;

    a_rdata_hold: assert property (@(posedge axis_clk) disable iff (!axis_rst_n)
        (axil.rvalid && !axil.rready) |=> (axil.rvalid && $stable(axil.rdata)));
    a_start_pulse: assert property (@(posedge axis_clk) disable iff (!axis_rst_n)
        eng_start |=> !eng_start);
    a_we_needs_en: assert property (@(posedge axis_clk) disable iff (!axis_rst_n)
        (tap_WE != 4'b0000) |-> tap_EN);
    a_port_exclusive: assert property (@(posedge axis_clk) disable iff (!axis_rst_n)
        !(wr_tap && rd_tap));

endmodule
